// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_W    = 8;
    localparam int BIT_IDX_W = $clog2(DATA_W);
    localparam int BAUD_W    = 16;

    localparam logic [BAUD_W-1:0] BAUD_DEFAULT = 16'd433;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..i_period and strobes o_tick in the last clock of each bit.
// o_tick_next is the strobe value for the following clock, so the caller can register outputs off it.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [BAUD_W-1:0] i_period,
    input  logic              i_clear,
    input  logic              i_restart,
    output logic              o_tick,
    output logic              o_tick_next
);

    logic [BAUD_W-1:0] r_cnt;
    logic [BAUD_W-1:0] w_cnt_next;
    logic              r_tick;

    // Next count: wraps at each bit boundary, held at zero while the line is idle
    always_comb begin
        w_cnt_next = {BAUD_W{1'b0}};
        if (i_clear || i_restart || r_tick) begin
            w_cnt_next = {BAUD_W{1'b0}};
        end else begin
            w_cnt_next = r_cnt + 16'd1;
        end
        o_tick_next = !i_clear && (w_cnt_next == i_period);
    end

    // Counter and strobe registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= {BAUD_W{1'b0}};
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= o_tick_next;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_tx_sm.sv
// UART transmitter: 8N1 framing with a one-byte holding register and a runtime baud period.
// Optional even parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_sm
    import uart_pkg::*;
#(
    parameter logic [BAUD_W-1:0] BAUD_RESET_PERIOD = BAUD_DEFAULT
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [DATA_W-1:0] dataLoadIn,
    input  logic              dataValidIn,
    input  logic              baudLoadHiIn,
    input  logic              baudLoadLoIn,
    output logic              readyOut,
    output logic              busyOut,
    output logic              doneOut,
    output logic              serialOut
);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [BAUD_W-1:0]     r_baud;
    logic [DATA_W-1:0]     r_hold;
    logic                  r_hold_valid;
    logic [DATA_W-1:0]     r_shift;
    logic [DATA_W-1:0]     w_shift_next;
    logic [BIT_IDX_W-1:0]  r_bit_idx;
    logic                  r_serial;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_serial_next;
    logic                  w_tick;
    logic                  w_tick_next;
    logic                  w_accept;
    logic                  w_baud_wr;
    logic                  w_load_shift;
    logic                  w_clear;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    // A baud load on the shared bus always claims the cycle, so the byte is refused
    assign w_accept     = dataValidIn && !r_hold_valid && !baudLoadHiIn && !baudLoadLoIn;
    assign w_baud_wr    = (r_state == ST_IDLE) && !r_hold_valid;
    assign w_load_shift = (w_state_next == ST_START) && (r_state != ST_START);
    assign w_clear      = (w_state_next == ST_IDLE);

    uart_baud_tick u_baud_tick (
        .i_clk       (clk),
        .i_rst_n     (resetN),
        .i_period    (r_baud),
        .i_clear     (w_clear),
        .i_restart   (w_load_shift),
        .o_tick      (w_tick),
        .o_tick_next (w_tick_next)
    );

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_valid) w_state_next = ST_START;
                else              w_state_next = ST_IDLE;
            end
            ST_START: begin
                if (w_tick) w_state_next = ST_DATA;
                else        w_state_next = ST_START;
            end
            ST_DATA: begin
                if (w_tick && (r_bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end else begin
                    w_state_next = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) w_state_next = ST_STOP;
                else        w_state_next = ST_PARITY;
            end
`endif
            ST_STOP: begin
                if (w_tick) w_state_next = r_hold_valid ? ST_START : ST_IDLE;
                else        w_state_next = ST_STOP;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: line level for the coming clock, derived from the next state
    always_comb begin
        w_shift_next = r_shift;
        if (w_load_shift) begin
            w_shift_next = r_hold;
        end else if ((r_state == ST_DATA) && w_tick) begin
            w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
        end else begin
            w_shift_next = r_shift;
        end
        case (w_state_next)
            ST_START:  w_serial_next = 1'b0;
            ST_DATA:   w_serial_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_serial_next = r_parity;
`endif
            ST_STOP:   w_serial_next = 1'b1;
            default:   w_serial_next = 1'b1;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_shift   <= {DATA_W{1'b0}};
            r_bit_idx <= {BIT_IDX_W{1'b0}};
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_shift   <= w_shift_next;
            if (w_load_shift) begin
                r_bit_idx <= {BIT_IDX_W{1'b0}};
            end else if ((r_state == ST_DATA) && w_tick) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
                r_bit_idx <= r_bit_idx;
            end
            r_serial  <= w_serial_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= (w_state_next == ST_STOP) && w_tick_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured with the byte because the shifter destroys it
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_parity <= 1'b0;
        end else if (w_load_shift) begin
            r_parity <= even_parity(r_hold);
        end else begin
            r_parity <= r_parity;
        end
    end
`endif

    // Holding register and baud period
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hold       <= {DATA_W{1'b0}};
            r_hold_valid <= 1'b0;
            r_baud       <= BAUD_RESET_PERIOD;
        end else begin
            if (w_accept) begin
                r_hold       <= dataLoadIn;
                r_hold_valid <= 1'b1;
            end else if (w_load_shift) begin
                r_hold_valid <= 1'b0;
            end else begin
                r_hold_valid <= r_hold_valid;
            end
            if (w_baud_wr && baudLoadHiIn) r_baud[15:8] <= dataLoadIn;
            if (w_baud_wr && baudLoadLoIn) r_baud[7:0]  <= dataLoadIn;
        end
    end

    assign readyOut  = ~r_hold_valid;
    assign busyOut   = r_busy;
    assign doneOut   = r_done;
    assign serialOut = r_serial;

endmodule

// File: tb/tb_uart_tx_sm.sv
// Scoreboard bench for uart_tx_sm: the stimulus queues expected frames, a monitor checks the line cycle by cycle.
module tb_uart_tx_sm;

    logic       clk;
    logic       resetN;
    logic [7:0] dataLoadIn;
    logic       dataValidIn;
    logic       baudLoadHiIn;
    logic       baudLoadLoIn;
    logic       readyOut;
    logic       busyOut;
    logic       doneOut;
    logic       serialOut;

    typedef struct {
        logic [7:0] d;
        int         p;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    uart_tx_sm dut (
        .clk          (clk),
        .resetN       (resetN),
        .dataLoadIn   (dataLoadIn),
        .dataValidIn  (dataValidIn),
        .baudLoadHiIn (baudLoadHiIn),
        .baudLoadLoIn (baudLoadLoIn),
        .readyOut     (readyOut),
        .busyOut      (busyOut),
        .doneOut      (doneOut),
        .serialOut    (serialOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Offer a byte; optionally queue its frame and check first-bit latency
    task automatic send(input logic [7:0] d, input int p, input bit lat, input bit want);
        int   g;
        exp_t e;
        g = 0;
        @(negedge clk);
        while (!readyOut && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("send_ready_timeout", (g < 20000), 1);
        e.d = d;
        e.p = p;
        if (want) exp_q.push_back(e);
        dataLoadIn  = d;
        dataValidIn = 1'b1;
        @(negedge clk);
        dataValidIn = 1'b0;
        chk("ready_drops_after_accept", readyOut, 0);
        if (lat) chk("line_high_before_start", serialOut, 1);
        @(negedge clk);
        if (lat) chk("start_bit_latency", serialOut, 0);
    endtask

    task automatic baud_load(input logic hi, input logic lo, input logic [7:0] d, input logic valid);
        @(negedge clk);
        dataLoadIn   = d;
        baudLoadHiIn = hi;
        baudLoadLoIn = lo;
        dataValidIn  = valid;
        @(negedge clk);
        baudLoadHiIn = 1'b0;
        baudLoadLoIn = 1'b0;
        dataValidIn  = 1'b0;
        if (valid) begin
            chk("load_wins_ready", readyOut, 1);
            chk("load_wins_no_busy", busyOut, 0);
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while ((busyOut || !readyOut) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("idle_timeout", (g < 20000), 1);
    endtask

    // Monitor: decode each frame bit by bit against the head of the queue
    initial begin
        exp_t        e;
        logic [10:0] bits;
        int          nb;
        bit          aborted;
        bit          chain;
        int          g;
        chain = 1'b0;
        forever begin
            if (!chain) @(negedge clk);
            chain = 1'b0;
            if (resetN && (serialOut == 1'b0)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 0, 1);
                    g = 0;
                    while (busyOut && g < 20000) begin
                        @(negedge clk);
                        g++;
                    end
                end else begin
                    e = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
                    bits = {1'b1, ^e.d, e.d, 1'b0};
                    nb   = 11;
`else
                    bits = {1'b0, 1'b1, e.d, 1'b0};
                    nb   = 10;
`endif
                    aborted = 1'b0;
                    for (int b = 0; b < nb && !aborted; b++) begin
                        for (int c = 0; c <= e.p && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (!resetN) begin
                                aborted = 1'b1;
                            end else begin
                                chk($sformatf("serial_d%0h_bit%0d_clk%0d", e.d, b, c), serialOut, bits[b]);
                                chk($sformatf("done_d%0h_bit%0d_clk%0d", e.d, b, c), doneOut,
                                    ((b == nb - 1) && (c == e.p)));
                                chk("busy_in_frame", busyOut, 1);
                            end
                        end
                    end
                    if (!aborted && exp_q.size() != 0) begin
                        @(negedge clk);
                        if (resetN) begin
                            chk("back_to_back_no_gap", serialOut, 0);
                            chain = (serialOut == 1'b0);
                        end
                    end
                end
            end else if (resetN) begin
                chk("idle_done_low", doneOut, 0);
                chk("idle_not_busy", busyOut, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN       = 1'b0;
        dataLoadIn   = 8'h00;
        dataValidIn  = 1'b0;
        baudLoadHiIn = 1'b0;
        baudLoadLoIn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_serial", serialOut, 1);
        chk("rst_ready", readyOut, 1);
        chk("rst_busy", busyOut, 0);
        chk("rst_done", doneOut, 0);
        resetN = 1'b1;

        // Period 0x01B1 -> 0x0103 -> 0x0003, both loads colliding with dataValidIn
        baud_load(1'b0, 1'b1, 8'h03, 1'b1);
        baud_load(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        chk("no_frame_after_loads", busyOut, 0);

        send(8'hA5, 3, 1'b1, 1'b1);
        wait_idle();

        send(8'h01, 3, 1'b1, 1'b1);
        send(8'h80, 3, 1'b0, 1'b1);
        wait_idle();

        // Both halves in one cycle -> 0x0202
        baud_load(1'b1, 1'b1, 8'h02, 1'b0);
        send(8'h96, 514, 1'b1, 1'b1);
        wait_idle();

        // Period 0: one-clock bits
        baud_load(1'b1, 1'b1, 8'h00, 1'b0);
        send(8'hE1, 0, 1'b1, 1'b1);
        wait_idle();

        baud_load(1'b0, 1'b1, 8'h03, 1'b0);
        send(8'hC6, 3, 1'b1, 1'b1);
        baud_load(1'b0, 1'b1, 8'h00, 1'b0);
        wait_idle();
        send(8'h29, 3, 1'b1, 1'b1);
        wait_idle();

        // Reset during bit 2 of 0xC3 with 0x5A waiting in the hold register
        send(8'hC3, 3, 1'b1, 1'b1);
        send(8'h5A, 3, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("pre_reset_line_low", serialOut, 0);
        #2;
        resetN = 1'b0;
        #1;
        chk("midframe_rst_serial", serialOut, 1);
        chk("midframe_rst_ready", readyOut, 1);
        chk("midframe_rst_busy", busyOut, 0);
        repeat (2) @(negedge clk);
        #2;
        resetN = 1'b1;
        repeat (20) @(negedge clk);
        chk("hold_abandoned", readyOut, 1);

        // Baud period is back to the reset default
        send(8'h3C, 433, 1'b1, 1'b1);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_sm.md
UART_TX_SM -- requirements
Module: uart_tx_sm

Interface
REQ-001 Parameter: BAUD_RESET_PERIOD, 16'd433, baud period loaded at reset; each bit lasts period+1 clocks.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetN  input  1  reset, asynchronous, active-low.
REQ-004 dataLoadIn  input  8  shared bus: transmit byte, or baud period byte during a baud load.
REQ-005 dataValidIn  input  1  byte offered on dataLoadIn.
REQ-006 baudLoadHiIn  input  1  load baudPeriod[15:8] from dataLoadIn.
REQ-007 baudLoadLoIn  input  1  load baudPeriod[7:0] from dataLoadIn.
REQ-008 readyOut  output  1  holding register empty; a byte can be accepted.
REQ-009 busyOut  output  1  a frame is being shifted out (state not IDLE).
REQ-010 doneOut  output  1  one-cycle pulse in the last clock of each stop bit.
REQ-011 serialOut  output  1  UART line, idle high, registered.

Function
REQ-012 A byte SHALL be accepted on a rising edge with dataValidIn=1, readyOut=1, baudLoadHiIn=0 and baudLoadLoIn=0; it is latched into the 8-bit holding register and readyOut drops on the next cycle.
REQ-013 readyOut SHALL equal the inverse of holdValid; no combinational path from any input to readyOut.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY (only with UART_TX_PARITY_EN), STOP.
REQ-015 IDLE -> START SHALL occur on the edge after holdValid=1; the same edge moves hold into the shift register and clears holdValid.
REQ-016 Latency: byte accepted at edge N gives serialOut=0 from edge N+1.
REQ-017 START drives 0, DATA drives shift bits LSB first (8 bits), STOP drives 1; each bit holds exactly baudPeriod+1 clocks.
REQ-018 The bit counter SHALL count 0..baudPeriod and wrap to 0 at every bit boundary; baudPeriod=0 gives 1-clock bits.
REQ-019 At the end of STOP, the FSM SHALL go to START with no idle gap if holdValid=1, otherwise to IDLE.
REQ-020 A new byte SHALL be accepted while shifting (hold empty); the in-flight frame is unaffected.
REQ-021 Baud loads SHALL take effect only in IDLE with holdValid=0; outside that they are ignored.
REQ-022 When a baud load and dataValidIn coincide, the load wins and the byte is not accepted.
REQ-023 baudLoadHiIn and baudLoadLoIn together in one cycle SHALL write dataLoadIn to both halves.

Reset
REQ-024 On resetN=0: state IDLE, serialOut=1, holdValid=0, readyOut=1, busyOut=0, doneOut=0, counters 0, baudPeriod=BAUD_RESET_PERIOD.
REQ-025 Reset mid-frame SHALL abandon the frame and the hold byte; the line goes high immediately.

Configuration
REQ-026 With UART_TX_PARITY_EN defined: a PARITY state between DATA and STOP drives even parity (XOR of the 8 data bits) for one bit time.
REQ-027 Without UART_TX_PARITY_EN: no PARITY state; DATA goes straight to STOP; frame is 10 bits.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum, the default baud constant and the data width (8).
REQ-029 Sub-module uart_baud_tick SHALL hold the baud counter and emit the bit-boundary strobe; it is restarted on IDLE->START.

Verification
REQ-030 Load period 3 (Hi=0x00, Lo=0x03), send 0xA5 -> serialOut 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; doneOut at clock 40.
REQ-031 Send 0x01 then 0x80 back-to-back -> second start bit begins the clock after the first stop bit; no idle cycle; two doneOut pulses.
REQ-032 With parity enabled, period 3, send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1; frame 44 clocks.
REQ-033 During a frame, pulse baudLoadLoIn with 0x00 -> ignored; the bit timing of that frame and later frames is unchanged.
REQ-034 Drop resetN mid-DATA -> serialOut=1 and readyOut=1 at once; after release, send 0x3C -> correct frame.
REQ-035 dataValidIn and baudLoadHiIn together in IDLE -> baudPeriod[15:8] updated, no frame starts, readyOut stays 1.
